// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serializer_pkg
// Brief    : Shared state encoding and defaults for the pattern serializer.
// Revision : 1.0 - initial release
// ============================================================================
package serializer_pkg;

    localparam int c_DEFAULT_WIDTH = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pattern_serializer.sv
`default_nettype none
// ============================================================================
// Module   : pattern_serializer
// Brief    : LSB-first serializer feeding a sequence detector, with pause.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pause,
    output logic                     x,
    output logic                     x_valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int                 c_IDX_W    = $clog2(WIDTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic               w_x_nxt;
    logic               w_x_valid_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [c_IDX_W-1:0] w_idx_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            x       <= w_x_nxt;
            x_valid <= w_x_valid_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
            bit_idx <= w_idx_nxt;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight
    // from a flop; r_shift holds only the bits not yet placed on x.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_x_nxt       = 1'b0;
        w_x_valid_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_idx_nxt     = '0;
        case (r_state)
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                if (load) begin
                    w_state_nxt   = SHIFT;
                    w_shift_nxt   = data_in >> 1;
                    w_x_nxt       = data_in[0];
                    w_x_valid_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                end
            end
            SHIFT: begin
                w_busy_nxt = 1'b1;
                if (pause) begin
                    w_x_nxt   = x;
                    w_idx_nxt = bit_idx;
                end else if (bit_idx == c_LAST_IDX) begin
                    w_state_nxt = DONE;
                    w_shift_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_shift_nxt   = r_shift >> 1;
                    w_x_nxt       = r_shift[0];
                    w_x_valid_nxt = 1'b1;
                    w_idx_nxt     = bit_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_shift_nxt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_serializer
// Brief    : Scoreboard bench for pattern_serializer (WIDTH=22 and WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_serializer;
    import serializer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, pause;
    logic [21:0] data_in;
    logic        x, x_valid, busy, done;
    logic [4:0]  bit_idx;

    logic        load4, pause4;
    logic [3:0]  data4;
    logic        x4, x_valid4, busy4, done4;
    logic [1:0]  bit_idx4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       is_done;
        logic       xb;
        logic [4:0] idx;
    } exp_t;

    exp_t q22[$];
    exp_t q4[$];

    localparam logic [21:0] c_WORD_A = 22'b0001111000000111000100;
    bit c_SEQ_A [22] = '{0,0,1,0,0,0,1,1,1,0,0,0,0,0,0,1,1,1,1,0,0,0};
    bit c_SEQ_B [22] = '{1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    bit c_SEQ_4 [4]  = '{0,1,0,1};

    always #5 clk = ~clk;

    pattern_serializer #(.WIDTH(22)) dut22 (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .pause(pause),
        .x(x), .x_valid(x_valid), .busy(busy), .done(done), .bit_idx(bit_idx)
    );

    pattern_serializer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .load(load4), .data_in(data4), .pause(pause4),
        .x(x4), .x_valid(x_valid4), .busy(busy4), .done(done4), .bit_idx(bit_idx4)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push22(input bit seq [22], input int n, input bit with_done);
        for (int i = 0; i < n; i++) q22.push_back('{1'b0, seq[i], 5'(i)});
        if (with_done) q22.push_back('{1'b1, 1'b0, 5'd0});
    endtask

    task automatic chk_idle22(input string tag);
        chk({tag, "_x"}, {31'd0, x}, 32'd0);
        chk({tag, "_x_valid"}, {31'd0, x_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_bit_idx"}, {27'd0, bit_idx}, 32'd0);
    endtask

    // Monitors: every valid bit or done pulse must match the next queued entry.
    always @(negedge clk) begin
        exp_t e;
        if (x_valid || done) begin
            chk("m22_event_expected", {31'd0, q22.size() != 0}, 32'd1);
            if (q22.size() != 0) begin
                e = q22.pop_front();
                chk("m22_kind_done", {31'd0, done}, {31'd0, e.is_done});
                chk("m22_x", {31'd0, x}, {31'd0, e.xb});
                chk("m22_busy", {31'd0, busy}, {31'd0, !e.is_done});
                if (!e.is_done) chk("m22_bit_idx", {27'd0, bit_idx}, {27'd0, e.idx});
                else            chk("m22_done_x_valid", {31'd0, x_valid}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (x_valid4 || done4) begin
            chk("m4_event_expected", {31'd0, q4.size() != 0}, 32'd1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                chk("m4_kind_done", {31'd0, done4}, {31'd0, e.is_done});
                chk("m4_x", {31'd0, x4}, {31'd0, e.xb});
                if (!e.is_done) chk("m4_bit_idx", {30'd0, bit_idx4}, {30'd0, e.idx[1:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load = 1'b0; pause = 1'b0; data_in = '0;
        load4 = 1'b0; pause4 = 1'b0; data4 = '0;
        step(); step();
        chk_idle22("reset");
        chk("reset_dut4_busy", {31'd0, busy4}, 32'd0);
        rst = 1'b0;

        // pause and stray data while idle must do nothing
        pause = 1'b1; data_in = 22'h2AAAAA;
        step();
        chk_idle22("idle_pause");
        pause = 1'b0;

        // Plain transfer: 22 bits, done on cycle 23
        data_in = c_WORD_A; load = 1'b1; push22(c_SEQ_A, 22, 1'b1);
        step();
        load = 1'b0; data_in = ~c_WORD_A;
        chk("a_first_busy", {31'd0, busy}, 32'd1);
        for (int c = 2; c <= 22; c++) step();
        chk("a_c22_done", {31'd0, done}, 32'd0);
        step();
        chk("a_c23_done", {31'd0, done}, 32'd1);
        step();
        chk_idle22("a_after");

        // Paused transfer: cycles 5-7 frozen, done on cycle 26
        data_in = c_WORD_A; load = 1'b1; push22(c_SEQ_A, 22, 1'b1);
        step();
        load = 1'b0;
        for (int c = 2; c <= 4; c++) step();
        pause = 1'b1;
        for (int c = 5; c <= 7; c++) begin
            step();
            chk("b_pause_x_valid", {31'd0, x_valid}, 32'd0);
            chk("b_pause_x", {31'd0, x}, {31'd0, c_SEQ_A[3]});
            chk("b_pause_bit_idx", {27'd0, bit_idx}, 32'd3);
            chk("b_pause_busy", {31'd0, busy}, 32'd1);
        end
        pause = 1'b0;
        for (int c = 8; c <= 25; c++) step();
        chk("b_c25_done", {31'd0, done}, 32'd0);
        step();
        chk("b_c26_done", {31'd0, done}, 32'd1);
        step();

        // load at bit_idx 10 is ignored
        data_in = c_WORD_A; load = 1'b1; push22(c_SEQ_A, 22, 1'b1);
        step();
        load = 1'b0;
        for (int c = 2; c <= 11; c++) step();
        chk("c_idx_at_load", {27'd0, bit_idx}, 32'd10);
        data_in = 22'h3FFFFF; load = 1'b1;
        step();
        load = 1'b0; data_in = 22'(32'($urandom));
        chk("c_idx_after_load", {27'd0, bit_idx}, 32'd11);
        for (int c = 13; c <= 23; c++) step();
        chk("c_c23_done", {31'd0, done}, 32'd1);
        step();

        // reset at bit_idx 8 discards the word; no done pulse
        data_in = c_WORD_A; load = 1'b1; push22(c_SEQ_A, 9, 1'b0);
        step();
        load = 1'b0;
        for (int c = 2; c <= 9; c++) step();
        chk("d_idx_before_rst", {27'd0, bit_idx}, 32'd8);
        rst = 1'b1; load = 1'b1; pause = 1'b1;
        step();
        rst = 1'b0; load = 1'b0; pause = 1'b0;
        chk_idle22("d_after_rst");
        chk("d_queue_drained", q22.size(), 32'd0);
        step();
        chk("d_no_done", {31'd0, done}, 32'd0);

        // clean restart, then back-to-back load in the DONE cycle
        data_in = c_WORD_A; load = 1'b1; push22(c_SEQ_A, 22, 1'b1);
        step();
        load = 1'b0;
        chk("e_restart_idx", {27'd0, bit_idx}, 32'd0);
        for (int c = 2; c <= 23; c++) step();
        chk("e_c23_done", {31'd0, done}, 32'd1);
        data_in = 22'h000001; load = 1'b1; push22(c_SEQ_B, 22, 1'b1);
        step();
        load = 1'b0; data_in = 22'h3FFFFF;
        chk("e_b2b_x", {31'd0, x}, 32'd1);
        chk("e_b2b_x_valid", {31'd0, x_valid}, 32'd1);
        for (int c = 2; c <= 22; c++) step();
        step();
        chk("e_second_done", {31'd0, done}, 32'd1);
        step();

        // WIDTH=4 instance
        data4 = 4'b1010; load4 = 1'b1;
        for (int i = 0; i < 4; i++) q4.push_back('{1'b0, c_SEQ_4[i], 5'(i)});
        q4.push_back('{1'b1, 1'b0, 5'd0});
        step();
        load4 = 1'b0; data4 = 4'b0000;
        for (int c = 2; c <= 4; c++) step();
        chk("w4_c4_done", {31'd0, done4}, 32'd0);
        step();
        chk("w4_c5_done", {31'd0, done4}, 32'd1);
        step(); step();

        chk("end_q22_empty", q22.size(), 32'd0);
        chk("end_q4_empty", q4.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
